vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA 640x480@60 Hz timing generator that drives the display connector and supplies the pixel coordinate bus consumed by the ball, paddle and brick renderers. It derives a pixel-rate enable from the system clock, runs horizontal and vertical scan counters, and produces registered sync, video-enable, coordinate and frame-tick outputs. It is the source end of the pixelX/pixelY interface; all object renderers sample its outputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel (1..16); 4 gives 25 MHz from 100 MHz
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- pixel_tick  output  1  one-clock pulse, once every CLK_DIV clocks; scan position advances on it
- pixel_x  output  10  current column, 0..H_TOTAL-1
- pixel_y  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- frame_tick  output  1  one-clock pulse at start of vertical blanking
- frame_count  output  8  frames completed (only with VGA_SYNC_FRAME_CNT_EN)

## Operation
- H_TOTAL = sum of H_* (800 default); V_TOTAL = sum of V_* (525 default).
- Divider counter div: 0..CLK_DIV-1, increments every clock, wraps to 0. pixel_tick = (div == CLK_DIV-1). CLK_DIV=1: pixel_tick constantly high after reset.
- On clock edge with pixel_tick high: pixel_x increments; at H_TOTAL-1 wraps to 0 and pixel_y increments; pixel_y at V_TOTAL-1 with pixel_x at H_TOTAL-1 wraps to 0.
- hsync low iff H_ACTIVE+H_FRONT <= pixel_x < H_ACTIVE+H_FRONT+H_SYNC (656..751 default).
- vsync low iff V_ACTIVE+V_FRONT <= pixel_y < V_ACTIVE+V_FRONT+V_SYNC (490..491 default).
- hsync, vsync, video_on are registered, computed from the next counter values so they are cycle-aligned with pixel_x/pixel_y (no skew).
- frame_tick high for exactly one clock: the first clock in which pixel_x==0 and pixel_y==V_ACTIVE are presented. Renderers update object positions on it.
- Counters are unsigned, 10 bits; no saturation, only explicit wrap.

## Timing
- Reset values: div=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, pixel_tick=0, frame_tick=0, frame_count=0.
- After reset release, pixel_tick first high in the CLK_DIV-th clock cycle; pixel_x becomes 1 at the edge ending that cycle.
- Each coordinate held for exactly CLK_DIV clocks. Line period H_TOTAL*CLK_DIV clocks; frame period H_TOTAL*V_TOTAL*CLK_DIV clocks (1,680,000 default).
- frame_tick coincides with the clock after the pixel_tick edge that moves to (0,V_ACTIVE); it never coincides with pixel_tick unless CLK_DIV=1.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous); scan restarts at (0,0) after release; no partial sync pulse is extended.

## Configuration
- VGA_SYNC_FRAME_CNT_EN defined: frame_count port present; 8-bit counter increments on each frame_tick, wraps 255->0, reset to 0.
- Undefined: frame_count port and counter absent; all other behaviour identical.

## Structure
- Shared package vga_pkg: default timing constants (H_ACTIVE..V_BACK, H_TOTAL, V_TOTAL), coordinate width (10), ball/screen bounds reused by renderers.
- One sub-module: vga_pixel_div (divider counter producing pixel_tick), parameterized by CLK_DIV.

## Test plan
- Reset, release, CLK_DIV=4 -> pixel_tick pulses at clocks 4,8,12...; pixel_x reads 0,0,0,0,1,... ; hsync=vsync=1, video_on=1.
- Run one line -> pixel_x reaches 799 then 0 with pixel_y 0->1; hsync low exactly for pixel_x 656..751 (96*4=384 clocks); video_on low for pixel_x 640..799.
- Run one frame -> vsync low only on pixel_y 490,491 (1600 pixel_ticks); pixel_y wraps 524->0; frame period 1,680,000 clocks.
- Check frame_tick -> single one-clock pulse per frame when (pixel_x,pixel_y)=(0,480); count exactly 1 per 1,680,000 clocks.
- Assert reset at pixel (700,491) during both sync pulses -> hsync, vsync go 1 and coordinates 0 without waiting for clock; restart timing matches first scenario.
- With VGA_SYNC_FRAME_CNT_EN, run 257 frames -> frame_count sequence 1..255,0,1; CLK_DIV=1 build -> pixel_tick stays high, frame period 420,000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, coordinate type and screen bounds used by the sync
// generator and the object renderers.
package vga_pkg;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 8;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int CLK_DIV_DEFAULT = 4;

  // Play-field limits for the ball renderer (top-left corner of an 8x8 ball).
  localparam int BALL_SIZE  = 8;
  localparam int BALL_X_MAX = H_ACTIVE - BALL_SIZE;
  localparam int BALL_Y_MAX = V_ACTIVE - BALL_SIZE;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic coord_t coord_inc_wrap(input coord_t v, input coord_t last);
    return (v == last) ? '0 : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate bus from the VGA sync generator to the renderers.
// Optional frame_count member exists only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  import vga_pkg::*;

  // Broadcast bus with no back-pressure: pixel_tick is the only qualifier and every
  // other member is valid in every clock; renderers cannot stall the scan.
  logic   pixel_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_tick;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                  frame_tick, frame_count);
  modport slave  (input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                  frame_tick, frame_count);
`else
  modport master (output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                  frame_tick);
  modport slave  (input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                  frame_tick);
`endif

endinterface

// File: rtl/vga_pixel_div.sv
// Pixel-rate enable: a 0..CLK_DIV-1 counter whose last count is the pixel_tick.
module vga_pixel_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic pixel_tick_o
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q;
  logic [3:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gated by reset so CLK_DIV=1 still shows a low tick while held in reset.
  assign pixel_tick_o = ~reset & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan generator: pixel/line counters with registered, skew-free sync, video
// enable and frame tick. Define VGA_SYNC_FRAME_CNT_EN to add the 8-bit frame counter.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_pkg::H_FRONT,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BACK   = vga_pkg::H_BACK,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_pkg::V_FRONT,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BACK   = vga_pkg::V_BACK,
  parameter int CLK_DIV  = vga_pkg::CLK_DIV_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FRONT + V_SYNC);

  logic   pixel_tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   frame_tick_q, frame_tick_d;

  vga_pixel_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clock        (clock),
    .reset        (reset),
    .pixel_tick_o (pixel_tick)
  );

  // Decodes use the next coordinates so the registered flags line up with x_q/y_q.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pixel_tick) begin
      x_d = coord_inc_wrap(x_q, H_LAST);
      if (x_q == H_LAST) begin
        y_d = coord_inc_wrap(y_q, V_LAST);
      end
    end
    hsync_d      = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d      = !((y_d >= VS_START) && (y_d < VS_END));
    video_on_d   = (x_d < H_VIS) && (y_d < V_VIS);
    frame_tick_d = pixel_tick && (x_d == '0) && (y_d == V_VIS);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (frame_tick_q) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign vga.frame_count = frame_count_q;
`endif

  assign vga.pixel_tick = pixel_tick;
  assign vga.pixel_x    = x_q;
  assign vga.pixel_y    = y_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing plus two reduced timings (CLK_DIV=2 and
// CLK_DIV=1) so whole frames fit in a short run; scoreboard against a cycle-count model.
module tb_vga_sync_gen;

  logic clock;
  logic reset;

  vga_sync_gen_if a_if ();
  vga_sync_gen_if b_if ();
  vga_sync_gen_if c_if ();

  vga_sync_gen u_dflt (
    .clock (clock),
    .reset (reset),
    .vga   (a_if)
  );

  vga_sync_gen #(
    .H_ACTIVE(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(2)
  ) u_small (
    .clock (clock),
    .reset (reset),
    .vga   (b_if)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1)
  ) u_tiny (
    .clock (clock),
    .reset (reset),
    .vga   (c_if)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // observed word: {frame_count, pixel_tick, frame_tick, hsync, vsync, video_on, x, y}
  logic [7:0]  fc_a, fc_b, fc_c;
  logic [32:0] obs_a, obs_b, obs_c;
`ifdef VGA_SYNC_FRAME_CNT_EN
  assign fc_a = a_if.frame_count;
  assign fc_b = b_if.frame_count;
  assign fc_c = c_if.frame_count;
`else
  assign fc_a = 8'd0;
  assign fc_b = 8'd0;
  assign fc_c = 8'd0;
`endif
  always_comb obs_a = {fc_a, a_if.pixel_tick, a_if.frame_tick, a_if.hsync, a_if.vsync,
                       a_if.video_on, a_if.pixel_x, a_if.pixel_y};
  always_comb obs_b = {fc_b, b_if.pixel_tick, b_if.frame_tick, b_if.hsync, b_if.vsync,
                       b_if.video_on, b_if.pixel_x, b_if.pixel_y};
  always_comb obs_c = {fc_c, c_if.pixel_tick, c_if.frame_tick, c_if.hsync, c_if.vsync,
                       c_if.video_on, c_if.pixel_x, c_if.pixel_y};

  localparam logic [32:0] RST_WORD = {8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  logic [32:0] exp_c_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc    = 0;
  bit tally_en = 1'b0;
  int hs_low_a, von_low_a, ptick_a, ftick_b, ftick_c, ptick_c;

  // Expected outputs n clocks after reset release, derived from elapsed time alone.
  function automatic logic [32:0] model(input int d, input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf, input int vs,
                                        input int vb, input int n);
    int ht, vt, p, x, y;
    logic [7:0] fc;
    logic ptick, ftick, hsy, vsy, von;
`ifdef VGA_SYNC_FRAME_CNT_EN
    int n0, per, cnt;
`endif
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    p     = n / d;
    x     = p % ht;
    y     = (p / ht) % vt;
    ptick = ((n % d) == d - 1);
    ftick = ((n % d) == 0) && (p > 0) && (x == 0) && (y == va);
    hsy   = !((x >= ha + hf) && (x < ha + hf + hs));
    vsy   = !((y >= va + vf) && (y < va + vf + vs));
    von   = (x < ha) && (y < va);
    fc    = 8'd0;
`ifdef VGA_SYNC_FRAME_CNT_EN
    n0  = va * ht * d;
    per = ht * vt * d;
    cnt = (n <= n0) ? 0 : ((n - n0 - 1) / per + 1);
    fc  = 8'(cnt);
`endif
    return {fc, ptick, ftick, hsy, vsy, von, 10'(x), 10'(y)};
  endfunction

  task automatic check_word(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver side: push what each DUT must present in cycle n
  task automatic push_model(input int n);
    exp_a_q.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, n));
    exp_b_q.push_back(model(2, 20, 2, 4, 2, 10, 2, 2, 3, n));
    exp_c_q.push_back(model(1, 4, 1, 1, 1, 2, 1, 1, 1, n));
  endtask

  task automatic push_reset();
    exp_a_q.push_back(RST_WORD);
    exp_b_q.push_back(RST_WORD);
    exp_c_q.push_back(RST_WORD);
  endtask

  task automatic pop_check();
    check_word("dflt", obs_a, exp_a_q.pop_front());
    check_word("small", obs_b, exp_b_q.pop_front());
    check_word("tiny", obs_c, exp_c_q.pop_front());
    if (tally_en) begin
      if (n_cyc < 3200 && !a_if.hsync)   hs_low_a++;
      if (n_cyc < 3200 && !a_if.video_on) von_low_a++;
      if (n_cyc < 3200 && a_if.pixel_tick) ptick_a++;
      if (b_if.frame_tick) ftick_b++;
      if (c_if.frame_tick) ftick_c++;
      if (c_if.pixel_tick) ptick_c++;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      n_cyc++;
      push_model(n_cyc);
      @(negedge clock);
      pop_check();
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    n_cyc = 0;
    push_model(0);
    #1;
    pop_check();
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    hs_low_a = 0; von_low_a = 0; ptick_a = 0; ftick_b = 0; ftick_c = 0; ptick_c = 0;

    // reset state while clock runs
    repeat (3) @(posedge clock);
    @(negedge clock);
    push_reset();
    pop_check();

    // release and scan: one default line, ten small frames, 272 tiny frames
    tally_en = 1'b1;
    release_reset();
    run(9499);
    tally_en = 1'b0;

    check_int("dflt_hsync_low_clocks_line0", hs_low_a, 96 * 4);
    check_int("dflt_video_off_clocks_line0", von_low_a, 160 * 4);
    check_int("dflt_pixel_ticks_line0", ptick_a, 800);
    check_int("small_frame_ticks", ftick_b, 10);
    check_int("tiny_frame_ticks", ftick_c, 272);
    check_int("tiny_pixel_tick_always", ptick_c, 9500);

    // walk the small DUT into both sync pulses, then hit reset between edges
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (b_if.pixel_x == 10'd24 && b_if.pixel_y == 10'd12) begin
        found = 1'b1;
        break;
      end
      run(1);
    end
    check_int("seek_sync_point", int'(found), 1);
    check_int("small_hsync_before_reset", int'(b_if.hsync), 0);
    check_int("small_vsync_before_reset", int'(b_if.vsync), 0);

    #2;
    reset = 1'b1;
    #1;
    push_reset();
    pop_check();

    repeat (2) @(posedge clock);
    release_reset();
    run(1199);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
